mult_hilo_ctrl: RTL and testbench
=================================

// Module: mult_hilo_ctrl
// PURPOSE
//  Sequencer and result stage wrapped around the 16x16 shift-add Multiplicador.
//  Takes MULT/MULTU requests from the execute stage, converts signed operands to magnitudes and starts the multiplier.
//  Waits for its Done, fixes the product sign and writes the result into the HI/LO registers.
//  Stalls the pipeline through Busy and serves MFHI/MFLO reads.
// PARAMETERS
//  W        16   operand width; product and HI:LO are 2*W
//  TIMEOUT  64   max cycles in WAIT before abort (must exceed multiplier latency)
// PORTS
//  Clk          in   1     single clock, rising edge
//  Reset        in   1     asynchronous, active-high; clears all state
//  Req          in   1     start request, sampled only in IDLE
//  Signed_Op    in   1     1 = MULT (two's complement), 0 = MULTU
//  Op_A         in   W     multiplicand from execute stage
//  Op_B         in   W     multiplier from execute stage
//  Busy         out  1     operation in flight; pipeline holds
//  Res_Valid    out  1     one-cycle pulse; HI/LO updated this edge
//  Err          out  1     sticky timeout flag
//  Rd_Sel       in   1     0 = LO, 1 = HI
//  Rd_Data      out  W     combinational HI/LO read
//  Mul_St       out  1     one-cycle start pulse to multiplier
//  Mul_A        out  W     magnitude of A, held stable IDLE->done
//  Mul_B        out  W     magnitude of B, held stable IDLE->done
//  Mul_Idle     in   1     multiplier ready for St
//  Mul_Done     in   1     multiplier product valid (level)
//  Mul_Produto  in   2W    unsigned product
// BEHAVIOUR
//  Reset (async, any state): state=IDLE.
//    Busy, Res_Valid, Err, Mul_St, Mul_A, Mul_B, HI, LO, timeout counter all = 0.
//    Reset during an operation aborts it; no HI/LO write.
//  States:
//    IDLE -> ISSUE -> WAIT -> FIX -> IDLE
//    WAIT -> IDLE on timeout
//  IDLE:
//    Req=1 at an edge:
//      - latch Mul_A=|Op_A|, Mul_B=|Op_B| (magnitudes only when Signed_Op=1).
//      - latch neg = Signed_Op & (A[W-1]^B[W-1]).
//      - clear Err; go to ISSUE.
//    Busy=1 from the next cycle.
//  Magnitude: |-2^(W-1)| = 2^(W-1), which fits unsigned in W bits; no overflow case.
//  ISSUE:
//    Mul_St=1 for exactly one cycle, taken in the first cycle with Mul_Idle=1.
//    Stay in ISSUE (St=0) while Mul_Idle=0. Then go to WAIT, counter=0.
//  WAIT:
//    Counter increments each cycle.
//    Mul_Done=1 -> capture Mul_Produto, go to FIX.
//    Counter reaches TIMEOUT-1 with Done still 0 -> Err=1, go to IDLE; HI/LO unchanged.
//    Done wins over timeout when both occur in the same cycle.
//  FIX (1 cycle): P = neg ? -Produto : Produto, modulo 2^(2W). {HI,LO} <= P.
//    Res_Valid=1 this cycle; next state IDLE.
//  Busy = (state != IDLE). Req while Busy is ignored; it is not queued.
//  Latency: Req edge -> ISSUE (1) -> St -> multiplier N cycles -> FIX (1).
//    Busy falls the cycle after Res_Valid.
//  Rd_Data = Rd_Sel ? HI : LO. Reads while Busy return the old HI/LO; the pipeline must stall MFHI/MFLO on Busy.
//  Mul_A and Mul_B hold their value after the operation until the next accepted Req.
// TESTING
//  1 MULTU A=FFFF, B=FFFF -> Res_Valid once, HI=FFFE, LO=0001, Busy low next cycle.
//  2 MULT A=FFFF (-1), B=0001 -> Mul_A=0001, Mul_B=0001, HI=FFFF, LO=FFFF.
//  3 MULT A=8000, B=8000 -> Mul_A=Mul_B=8000, HI=4000, LO=0000.
//    Same with B=0001 -> HI=FFFF, LO=8000.
//  4 Second Req pulsed during WAIT with different operands -> ignored.
//    HI/LO hold the first result; exactly one Mul_St pulse.
//  5 Stub multiplier with Done stuck at 0 -> Err=1 after TIMEOUT WAIT cycles, HI/LO unchanged.
//    Next Req clears Err.
//  6 Reset asserted mid-WAIT, between clock edges -> Busy=0, HI=LO=0 immediately.
//    Then a fresh MULTU 3x5 -> LO=000F.

Source files
------------

// File: rtl/mult_hilo_ctrl_if.sv
// Bundle between the execute stage, the HI/LO sequencer and the shift-add multiplier.
// The slave side is the sequencer; the master side is everything around it.
interface mult_hilo_ctrl_if #(
    parameter int unsigned W = 16
);
    logic           req;
    logic           signed_op;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           busy;
    logic           res_valid;
    logic           err;
    logic           rd_sel;
    logic [W-1:0]   rd_data;
    logic           mul_st;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_idle;
    logic           mul_done;
    logic [2*W-1:0] mul_produto;

    modport master (
        output req, signed_op, op_a, op_b, rd_sel, mul_idle, mul_done, mul_produto,
        input  busy, res_valid, err, rd_data, mul_st, mul_a, mul_b
    );

    modport slave (
        input  req, signed_op, op_a, op_b, rd_sel, mul_idle, mul_done, mul_produto,
        output busy, res_valid, err, rd_data, mul_st, mul_a, mul_b
    );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// MULT/MULTU sequencer: feeds operand magnitudes to an unsigned shift-add multiplier,
// restores the product sign, writes HI/LO and serves MFHI/MFLO reads.
module mult_hilo_ctrl #(
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    mult_hilo_ctrl_if.slave bus
);
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StFix
    } state_e;

    state_e          state_q;
    logic [W-1:0]    mul_a_q;
    logic [W-1:0]    mul_b_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic [2*W-1:0]  prod_q;
    logic            neg_q;
    logic            err_q;
    logic [CntW-1:0] cnt_q;

    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic            neg_d;
    logic [2*W-1:0]  prod_fixed;
    logic            timeout_hit;

    // |-2^(W-1)| wraps to 2^(W-1), which is exactly right when read as unsigned.
    always_comb begin
        mag_a       = (bus.signed_op && bus.op_a[W-1]) ? -bus.op_a : bus.op_a;
        mag_b       = (bus.signed_op && bus.op_b[W-1]) ? -bus.op_b : bus.op_b;
        neg_d       = bus.signed_op & (bus.op_a[W-1] ^ bus.op_b[W-1]);
        prod_fixed  = neg_q ? -prod_q : prod_q;
        timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        mul_a_q <= mag_a;
                        mul_b_q <= mag_b;
                        neg_q   <= neg_d;
                        err_q   <= 1'b0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.mul_idle) begin
                        cnt_q   <= '0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Done has priority over a timeout landing in the same cycle.
                    if (bus.mul_done) begin
                        prod_q  <= bus.mul_produto;
                        state_q <= StFix;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StFix: begin
                    {hi_q, lo_q} <= prod_fixed;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // St is qualified by Idle in the same cycle so the multiplier never misses it.
    assign bus.mul_st    = (state_q == StIssue) && bus.mul_idle;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.res_valid = (state_q == StFix);
    assign bus.err       = err_q;
    assign bus.rd_data   = bus.rd_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: directed corner cases plus random MULT/MULTU traffic
// against a stub multiplier and an arithmetic reference for HI:LO.
module tb_mult_hilo_ctrl;
    localparam int unsigned W       = 16;
    localparam int unsigned TIMEOUT = 64;

    logic clk;
    logic rst;

    mult_hilo_ctrl_if #(.W(W)) bus ();

    mult_hilo_ctrl #(
        .W      (W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hilo;

    // Stub multiplier: fixed latency after St, or never finishes when stuck.
    logic        idle_r;
    logic        done_r;
    logic        run_r;
    logic [31:0] prod_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    int unsigned cnt_r;
    int unsigned mdl_lat;
    bit          stuck;
    bit          idle_block;
    int unsigned st_count = 0;
    int unsigned rv_count = 0;

    assign bus.mul_idle    = idle_r & ~idle_block;
    assign bus.mul_done    = done_r;
    assign bus.mul_produto = prod_r;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_r <= 1'b1;
            done_r <= 1'b0;
            run_r  <= 1'b0;
            prod_r <= '0;
            cnt_r  <= 0;
            a_r    <= '0;
            b_r    <= '0;
        end else if (bus.mul_st && bus.mul_idle) begin
            done_r <= 1'b0;
            a_r    <= bus.mul_a;
            b_r    <= bus.mul_b;
            cnt_r  <= mdl_lat;
            run_r  <= !stuck;
            idle_r <= stuck;
        end else if (run_r) begin
            if (cnt_r <= 1) begin
                done_r <= 1'b1;
                idle_r <= 1'b1;
                run_r  <= 1'b0;
                prod_r <= {16'b0, a_r} * {16'b0, b_r};
            end else begin
                cnt_r <= cnt_r - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mul_st) st_count <= st_count + 1;
        if (bus.res_valid) rv_count <= rv_count + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input bit s, input logic [15:0] a,
                                             input logic [15:0] b);
        longint pa;
        longint pb;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        return 32'(pa * pb);
    endfunction

    function automatic logic [15:0] ref_mag(input bit s, input logic [15:0] a);
        longint v;
        v = s ? longint'($signed(a)) : longint'(a);
        if (v < 0) v = -v;
        return 16'(v);
    endfunction

    task automatic read_hilo(output logic [15:0] hi, output logic [15:0] lo);
        bus.rd_sel = 1'b1;
        #1 hi = bus.rd_data;
        bus.rd_sel = 1'b0;
        #1 lo = bus.rd_data;
    endtask

    task automatic run_op(input bit s, input logic [15:0] a, input logic [15:0] b,
                          input int unsigned lat, input int unsigned hold, input bit second);
        int unsigned st0;
        int unsigned rv0;
        bit          got;
        logic [15:0] hi;
        logic [15:0] lo;
        st0        = st_count;
        rv0        = rv_count;
        mdl_lat    = lat;
        stuck      = 1'b0;
        idle_block = (hold != 0);
        @(negedge clk);
        bus.req       = 1'b1;
        bus.signed_op = s;
        bus.op_a      = a;
        bus.op_b      = b;
        @(negedge clk);
        bus.req       = 1'b0;
        bus.op_a      = 16'($urandom);
        bus.op_b      = 16'($urandom);
        bus.signed_op = 1'($urandom);
        check_eq("busy_after_req", 64'(bus.busy), 64'(1));
        check_eq("err_cleared", 64'(bus.err), 64'(0));
        check_eq("mul_a", 64'(bus.mul_a), 64'(ref_mag(s, a)));
        check_eq("mul_b", 64'(bus.mul_b), 64'(ref_mag(s, b)));
        repeat (hold) @(negedge clk);
        idle_block = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            bus.req = second && (i == 2);
            if (second && i == 2) begin
                bus.op_a      = a ^ 16'h5a5a;
                bus.op_b      = b + 16'd1;
                bus.signed_op = !s;
            end
            if (bus.res_valid) begin
                got = 1'b1;
                check_eq("rd_old_during_fix", 64'(bus.rd_data), 64'(exp_hilo[15:0]));
            end
        end
        bus.req = 1'b0;
        check_eq("res_valid_seen", 64'(got), 64'(1));
        exp_hilo = ref_prod(s, a, b);
        @(negedge clk);
        check_eq("busy_fall", 64'(bus.busy), 64'(0));
        read_hilo(hi, lo);
        check_eq("hi", 64'(hi), 64'(exp_hilo[31:16]));
        check_eq("lo", 64'(lo), 64'(exp_hilo[15:0]));
        check_eq("mul_a_held", 64'(bus.mul_a), 64'(ref_mag(s, a)));
        check_eq("mul_b_held", 64'(bus.mul_b), 64'(ref_mag(s, b)));
        check_eq("st_pulses", 64'(st_count - st0), 64'(1));
        check_eq("rv_pulses", 64'(rv_count - rv0), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] corners [5];
        logic [15:0] ra;
        logic [15:0] rb;
        int unsigned rv0;
        int unsigned n;
        int unsigned rlat;

        corners = '{16'h0000, 16'hffff, 16'h8000, 16'h0001, 16'h7fff};
        rst           = 1'b1;
        bus.req       = 1'b0;
        bus.signed_op = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.rd_sel    = 1'b0;
        mdl_lat       = 4;
        stuck         = 1'b0;
        idle_block    = 1'b0;
        exp_hilo      = '0;

        #2;
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check_eq("rst_err", 64'(bus.err), 64'(0));
        check_eq("rst_mul_st", 64'(bus.mul_st), 64'(0));
        check_eq("rst_mul_a", 64'(bus.mul_a), 64'(0));
        check_eq("rst_mul_b", 64'(bus.mul_b), 64'(0));
        read_hilo(hi, lo);
        check_eq("rst_hilo", 64'({hi, lo}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, 16'hffff, 16'hffff, 6, 0, 1'b0);
        run_op(1'b1, 16'hffff, 16'h0001, 5, 1, 1'b0);
        run_op(1'b1, 16'h8000, 16'h8000, 7, 0, 1'b0);
        run_op(1'b1, 16'h8000, 16'h0001, 4, 2, 1'b0);
        run_op(1'b0, 16'h1234, 16'h5678, 8, 0, 1'b1);

        // Multiplier never signals Done: expect an abort with HI/LO untouched.
        rv0        = rv_count;
        stuck      = 1'b1;
        mdl_lat    = 5;
        idle_block = 1'b0;
        @(negedge clk);
        bus.req       = 1'b1;
        bus.signed_op = 1'b0;
        bus.op_a      = 16'h00ff;
        bus.op_b      = 16'h0101;
        @(negedge clk);
        bus.req = 1'b0;
        n = 1;
        while (!bus.err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("timeout_cycles", 64'(n), 64'(TIMEOUT + 2));
        check_eq("timeout_err", 64'(bus.err), 64'(1));
        check_eq("timeout_busy", 64'(bus.busy), 64'(0));
        check_eq("timeout_no_rv", 64'(rv_count - rv0), 64'(0));
        read_hilo(hi, lo);
        check_eq("timeout_hilo", 64'({hi, lo}), 64'(exp_hilo));
        run_op(1'b1, 16'h7fff, 16'h7fff, 5, 0, 1'b0);

        // Reset between edges in the middle of WAIT.
        mdl_lat = 20;
        stuck   = 1'b0;
        @(negedge clk);
        bus.req       = 1'b1;
        bus.signed_op = 1'b1;
        bus.op_a      = 16'h1234;
        bus.op_b      = 16'h4321;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_reset_busy", 64'(bus.busy), 64'(1));
        #1 rst = 1'b1;
        #1 check_eq("async_rst_busy", 64'(bus.busy), 64'(0));
        read_hilo(hi, lo);
        check_eq("async_rst_hilo", 64'({hi, lo}), 64'(0));
        exp_hilo = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 16'h0003, 16'h0005, 6, 0, 1'b0);
        check_eq("fresh_lo", 64'(exp_hilo[15:0]), 64'(16'h000f));

        for (int k = 0; k < 16; k++) begin
            ra   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            rb   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            rlat = $urandom_range(1, 10);
            run_op(1'($urandom), ra, rb, rlat, $urandom_range(0, 2),
                   (rlat >= 4) && ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
